uart_tx_param: RTL and testbench

Parametrised UART transmitter, the next generation of the fixed 8N1 serial sender. It adds configurable data width, stop-bit count and bit period, a valid/ready input handshake with a one-entry holding register for back-to-back frames, and optional parity. It sits between any sysclk-domain producer and the board TX pin.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_tx_param_baud_gen.sv | 25 ++
 rtl/uart_tx_param.sv | 135 +++++++++++++
 tb/tb_uart_tx_param.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the parametrised UART transmitter: FSM state encoding and
// parity mode codes (parity is only used when UART_TX_PARITY_EN is defined).
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

endpackage

// File: rtl/uart_tx_param_baud_gen.sv
// Bit-period counter: counts 0..CLK_DIV-1 on sysclk and strobes bit_end on the
// last count; clear parks it at 0 so a frame starts on a full period.
module baud_gen #(
  parameter int CLK_DIV = 5208
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (clear || bit_end) cnt <= '0;
    else                       cnt <= cnt + CW'(1);
  end

  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready holding register.
// Optional parity (parity_mode port, PARITY state) under UART_TX_PARITY_EN.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 5208,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
`ifdef UART_TX_PARITY_EN
  input  logic [1:0]           parity_mode,
`endif
  output logic                 txd,
  output logic                 busy
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] DLAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] SLAST = BW'(STOP_BITS - 1);

  tx_state_t state, state_n;
  logic full, full_n, hs, load, bit_end, txd_n;
  logic [DATA_BITS-1:0] hold_data, shift_reg, shift_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;

  assign tx_ready = !full;
  assign hs       = tx_valid && !full;

  baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .clear  (state == IDLE),
    .bit_end(bit_end)
  );

`ifdef UART_TX_PARITY_EN
  logic [1:0] hold_mode;
  logic       par_en, par_bit;

  // Mode and parity bit are frozen per frame at load, from the held entry.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      hold_mode <= PAR_NONE;
      par_en    <= 1'b0;
      par_bit   <= 1'b0;
    end else begin
      if (hs) hold_mode <= parity_mode;
      if (load) begin
        par_en  <= (hold_mode == PAR_EVEN) || (hold_mode == PAR_ODD);
        par_bit <= (^hold_data) ^ (hold_mode == PAR_ODD);
      end
    end
  end
`endif

  always_comb begin
    state_n   = state;
    shift_n   = shift_reg;
    bit_cnt_n = bit_cnt;
    load      = 1'b0;
    case (state)
      IDLE:  if (full) load = 1'b1;
      START: if (bit_end) state_n = DATA;
      DATA: if (bit_end) begin
        if (bit_cnt == DLAST) begin
          bit_cnt_n = '0;
`ifdef UART_TX_PARITY_EN
          state_n   = par_en ? PARITY : STOP;
`else
          state_n   = STOP;
`endif
        end else begin
          bit_cnt_n = bit_cnt + BW'(1);
          shift_n   = shift_reg >> 1;
        end
      end
      PARITY: if (bit_end) state_n = STOP;
      STOP: if (bit_end) begin
        if (bit_cnt == SLAST) begin
          bit_cnt_n = '0;
          if (full) load = 1'b1;
          else      state_n = IDLE;
        end else begin
          bit_cnt_n = bit_cnt + BW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    if (load) begin
      state_n   = START;
      shift_n   = hold_data;
      bit_cnt_n = '0;
    end

    full_n = full;
    if (load) full_n = 1'b0;
    if (hs)   full_n = 1'b1;

    // Line level follows the next state so txd leaves a flop with no input path.
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_n = par_bit;
`endif
      default: txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      full      <= 1'b0;
      hold_data <= '0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      txd       <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      full      <= full_n;
      shift_reg <= shift_n;
      bit_cnt   <= bit_cnt_n;
      txd       <= txd_n;
      busy      <= full_n || (state_n != IDLE);
      if (hs) hold_data <= tx_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: 8N1 instance and a 7-bit/2-stop instance
// (the latter exercises parity when UART_TX_PARITY_EN is defined).
module tb_uart_tx_param;

  localparam int CD = 16;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  logic [7:0] tx_data1 = '0;
  logic       tx_valid1 = 1'b0, tx_ready1, txd1, busy1;
  logic [6:0] tx_data2 = '0;
  logic       tx_valid2 = 1'b0, tx_ready2, txd2, busy2;
`ifdef UART_TX_PARITY_EN
  logic [1:0] parity_mode1 = 2'b00;
  logic [1:0] parity_mode2 = 2'b00;
`endif
  int errors = 0;
  int checks = 0;

  always #5 sysclk = ~sysclk;

  uart_tx_param #(.CLK_DIV(CD), .DATA_BITS(8), .STOP_BITS(1)) dut1 (
    .sysclk  (sysclk),
    .rst_n   (rst_n),
    .tx_data (tx_data1),
    .tx_valid(tx_valid1),
    .tx_ready(tx_ready1),
`ifdef UART_TX_PARITY_EN
    .parity_mode(parity_mode1),
`endif
    .txd     (txd1),
    .busy    (busy1)
  );

  uart_tx_param #(.CLK_DIV(CD), .DATA_BITS(7), .STOP_BITS(2)) dut2 (
    .sysclk  (sysclk),
    .rst_n   (rst_n),
    .tx_data (tx_data2),
    .tx_valid(tx_valid2),
    .tx_ready(tx_ready2),
`ifdef UART_TX_PARITY_EN
    .parity_mode(parity_mode2),
`endif
    .txd     (txd2),
    .busy    (busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  function automatic logic cur_txd(input int w);
    return (w == 1) ? txd1 : txd2;
  endfunction

  function automatic logic cur_rdy(input int w);
    return (w == 1) ? tx_ready1 : tx_ready2;
  endfunction

  // One handshake; returns just after the accepting edge.
  task automatic send(input int w, input logic [8:0] d);
    if (w == 1) begin tx_data1 = d[7:0]; tx_valid1 = 1'b1; end
    else        begin tx_data2 = d[6:0]; tx_valid2 = 1'b1; end
    tick();
    tx_valid1 = 1'b0;
    tx_valid2 = 1'b0;
  endtask

  // bits[0] is the start bit; each level must hold for CD samples.
  task automatic frame_check(input string tag, input int w, input logic [15:0] bits,
                             input int nbits, input int skip, output int rdy_hi);
    int bad;
    rdy_hi = 0;
    for (int b = 0; b < nbits; b++) begin
      bad = 0;
      for (int c = (b == 0) ? skip : 0; c < CD; c++) begin
        if (cur_txd(w) !== bits[b]) bad++;
        if (cur_rdy(w) === 1'b1) rdy_hi++;
        tick();
      end
      check($sformatf("%s bit%0d", tag, b), bad, 0);
    end
  endtask

  initial begin
    int bad;
    int rh;

    // Reset then idle
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (txd1 !== 1'b1 || tx_ready1 !== 1'b1 || busy1 !== 1'b0) bad++;
      if (txd2 !== 1'b1 || tx_ready2 !== 1'b1 || busy2 !== 1'b0) bad++;
      tick();
    end
    check("idle after reset", bad, 0);

    // 8N1 frame 0xA5, start bit two cycles after handshake
    send(1, 9'h0A5);
    check("ready low after hs", tx_ready1, 1'b0);
    check("busy after hs", busy1, 1'b1);
    check("txd idle at hs+1", txd1, 1'b1);
    tick();
    frame_check("a5", 1, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 0, rh);
    check("busy end a5", busy1, 1'b0);
    check("ready end a5", tx_ready1, 1'b1);
    check("txd idle end a5", txd1, 1'b1);

    // Back-to-back 0x00 then 0xFF
    send(1, 9'h000);
    tick();
    check("b2b start", txd1, 1'b0);
    check("ready after load", tx_ready1, 1'b1);
    tx_data1  = 8'hFF;
    tx_valid1 = 1'b1;
    tick();
    tx_valid1 = 1'b0;
    frame_check("b2b f1", 1, {6'b0, 1'b1, 8'h00, 1'b0}, 10, 1, rh);
    check("f1 ready low cycles", rh, 0);
    frame_check("b2b f2", 1, {6'b0, 1'b1, 8'hFF, 1'b0}, 10, 0, rh);
    check("f2 ready high cycles", rh, CD * 10);
    check("busy end b2b", busy1, 1'b0);

`ifdef UART_TX_PARITY_EN
    // Even parity, mode changed to odd after accept: frame stays even
    parity_mode2 = 2'b01;
    send(2, 9'h055);
    parity_mode2 = 2'b10;
    tick();
    frame_check("p even", 2, {5'b0, 2'b11, 1'b0, 7'h55, 1'b0}, 11, 0, rh);
    // Odd parity, mode changed to even after accept
    send(2, 9'h055);
    parity_mode2 = 2'b01;
    tick();
    frame_check("p odd", 2, {5'b0, 2'b11, 1'b1, 7'h55, 1'b0}, 11, 0, rh);
    // Mode 11 behaves as no parity
    parity_mode2 = 2'b11;
    send(2, 9'h055);
    tick();
    frame_check("p mode3", 2, {6'b0, 2'b11, 7'h55, 1'b0}, 10, 0, rh);
`else
    send(2, 9'h055);
    tick();
    frame_check("7n2", 2, {6'b0, 2'b11, 7'h55, 1'b0}, 10, 0, rh);
`endif
    check("busy2 end", busy2, 1'b0);

    // Reset asserted during data bit 3 (a low bit of 0xA5)
    send(1, 9'h0A5);
    tick();
    repeat (69) tick();
    check("pre-reset txd", txd1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async rst txd", txd1, 1'b1);
    check("async rst ready", tx_ready1, 1'b1);
    check("async rst busy", busy1, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("txd after release", txd1, 1'b1);
    send(1, 9'h05A);
    tick();
    frame_check("post rst", 1, {6'b0, 1'b1, 8'h5A, 1'b0}, 10, 0, rh);
    check("busy end post rst", busy1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
